// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the gated SR latch bank controller.
//   sr_state_t : sequencing FSM states
//   OP_*       : command opcodes (set / clear)
//   SRC_*      : requester identifiers reported on done_src
//   max_int    : elaboration-time helper for sizing counters
package sr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    HOLD   = 3'd3,
    SETTLE = 3'd4,
    CHECK  = 3'd5
  } sr_state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock and synchronous active-high reset
//   req      : request vector, bit 0 = A, bit 1 = B
//   advance  : a granted handshake completed this cycle
//   grant    : one-hot (or zero) combinational grant
// When both request, the side not served last wins; after reset A wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // High when B was the most recently served requester.
  logic last_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (advance) begin
      last_b <= grant[1];
    end
  end

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0] & (~req[1] | last_b);
    grant[1] = req[1] & (~req[0] | ~last_b);
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Controller for a bank of N gated SR latches.
//   a_valid/a_op/a_idx/a_ready : requester A command handshake (op 1=set)
//   b_valid/b_op/b_idx/b_ready : requester B command handshake
//   latch_s/latch_r/latch_en   : per-latch S, R and gate drives (registered)
//   q_in                       : latch Q readback
//   busy                       : FSM not idle
//   done/done_src/err          : completion pulse, its requester, its status
//   err_sticky                 : any err since reset
// Each command runs SETUP -> PULSE -> HOLD -> SETTLE -> CHECK; an index
// beyond the bank skips straight to CHECK and reports err.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N          = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic             a_op,
  input  logic [IDX_W-1:0] a_idx,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_op,
  input  logic [IDX_W-1:0] b_idx,
  output logic             b_ready,
  output logic [N-1:0]     latch_s,
  output logic [N-1:0]     latch_r,
  output logic [N-1:0]     latch_en,
  input  logic [N-1:0]     q_in,
  output logic             busy,
  output logic             done,
  output logic             done_src,
  output logic             err,
  output logic             err_sticky
);

  localparam int CNT_MAX = max_int(PULSE_CYC, SETTLE_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N);

  sr_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [1:0]       grant;
  logic             accept;
  logic             sel_op, sel_src, sel_bad;
  logic [IDX_W-1:0] sel_idx;

  logic             cmd_op, cmd_src, cmd_bad;
  logic [IDX_W-1:0] cmd_idx;

  // Command as seen by the cycle being entered (fresh on accept).
  logic             op_n, src_n, bad_n, q_bit;
  logic [IDX_W-1:0] idx_n;

  logic [N-1:0]     s_nxt, r_nxt, en_nxt;
  logic             done_nxt, err_nxt;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({b_valid, a_valid}),
    .advance (accept),
    .grant   (grant)
  );

  assign a_ready = (state == IDLE) & grant[0];
  assign b_ready = (state == IDLE) & grant[1];
  assign accept  = a_ready | b_ready;

  assign sel_src = grant[1];
  assign sel_op  = grant[1] ? b_op  : a_op;
  assign sel_idx = grant[1] ? b_idx : a_idx;
  assign sel_bad = ({1'b0, sel_idx} >= N_LIM);

  assign op_n  = accept ? sel_op  : cmd_op;
  assign src_n = accept ? sel_src : cmd_src;
  assign bad_n = accept ? sel_bad : cmd_bad;
  assign idx_n = accept ? sel_idx : cmd_idx;

  // Command register: data only, qualified by accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_op  <= sel_op;
      cmd_src <= sel_src;
      cmd_bad <= sel_bad;
      cmd_idx <= sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = sel_bad ? CHECK : SETUP;
        end
      end
      SETUP: begin
        state_nxt = PULSE;
        cnt_nxt   = CNT_W'(PULSE_CYC - 1);
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        state_nxt = SETTLE;
        cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so that the
  // registered lines line up with the FSM state cycle for cycle.
  always_comb begin
    s_nxt    = '0;
    r_nxt    = '0;
    en_nxt   = '0;
    q_bit    = 1'b0;
    done_nxt = (state_nxt == CHECK);
    if (!bad_n) begin
      q_bit = q_in[idx_n];
      if (state_nxt inside {SETUP, PULSE, HOLD}) begin
        s_nxt[idx_n] = op_n;
        r_nxt[idx_n] = ~op_n;
      end
      if (state_nxt == PULSE) begin
        en_nxt[idx_n] = 1'b1;
      end
    end
    err_nxt = done_nxt & (bad_n | (q_bit != op_n));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch_s    <= '0;
      latch_r    <= '0;
      latch_en   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_src   <= SRC_A;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      latch_s    <= s_nxt;
      latch_r    <= r_nxt;
      latch_en   <= en_nxt;
      busy       <= (state_nxt != IDLE);
      done       <= done_nxt;
      err        <= err_nxt;
      err_sticky <= err_sticky | err_nxt;
      if (done_nxt) begin
        done_src <= src_n;
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Self-checking bench for sr_latch_ctrl: a 4-latch bank with behavioural
// gated SR latches fed back to q_in, plus a 3-latch instance for the
// out-of-range index case.
module tb_sr_latch_ctrl;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       a_valid, a_op, b_valid, b_op;
  logic [1:0] a_idx, b_idx;
  logic       a_ready, b_ready;
  logic [N-1:0] latch_s, latch_r, latch_en, q_in;
  logic       busy, done, done_src, err, err_sticky;

  logic [N-1:0] q_lat = '0;
  logic [N-1:0] stuck0 = '0;

  logic       c_valid, c_op, c_b_valid, c_b_op;
  logic [1:0] c_idx, c_b_idx;
  logic       c_ready, c_b_ready;
  logic [2:0] c_s, c_r, c_en, c_q;
  logic       c_busy, c_done, c_done_src, c_err, c_err_sticky;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [N-1:0] s_seen, r_seen, en_seen, prev_s, prev_r, prev_en;
  int en_cnt;

  typedef struct {
    logic       src;
    logic       op;
    logic [1:0] idx;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[8];

  sr_latch_ctrl #(.N(N), .PULSE_CYC(2), .SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_op(a_op), .a_idx(a_idx), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_idx(b_idx), .b_ready(b_ready),
    .latch_s(latch_s), .latch_r(latch_r), .latch_en(latch_en), .q_in(q_in),
    .busy(busy), .done(done), .done_src(done_src), .err(err),
    .err_sticky(err_sticky)
  );

  sr_latch_ctrl #(.N(3), .PULSE_CYC(2), .SETTLE_CYC(1)) dut3 (
    .clk(clk), .rst(rst),
    .a_valid(c_valid), .a_op(c_op), .a_idx(c_idx), .a_ready(c_ready),
    .b_valid(c_b_valid), .b_op(c_b_op), .b_idx(c_b_idx), .b_ready(c_b_ready),
    .latch_s(c_s), .latch_r(c_r), .latch_en(c_en), .q_in(c_q),
    .busy(c_busy), .done(c_done), .done_src(c_done_src), .err(c_err),
    .err_sticky(c_err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural gated SR latches: transparent while the gate is high.
  always @(latch_s, latch_r, latch_en) begin
    for (int i = 0; i < N; i++) begin
      if (latch_en[i]) begin
        if (latch_s[i]) q_lat[i] = 1'b1;
        else if (latch_r[i]) q_lat[i] = 1'b0;
      end
    end
  end

  assign q_in = q_lat & ~stuck0;
  assign c_q  = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready(input logic src, output logic got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (src ? b_ready : a_ready) got = 1'b1;
    end
  endtask

  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
  endtask

  task automatic clear_seen();
    s_seen  = '0;
    r_seen  = '0;
    en_seen = '0;
    en_cnt  = 0;
  endtask

  // Issue one command, leave the bench at the negedge of its done cycle.
  task automatic run_cmd(input logic src, input logic op, input logic [1:0] idx,
                         output int lat, output logic rdy_after);
    logic got;
    int   t_acc;
    @(posedge clk); #1;
    if (src) begin b_valid = 1'b1; b_op = op; b_idx = idx; end
    else     begin a_valid = 1'b1; a_op = op; a_idx = idx; end
    wait_ready(src, got);
    chk("ready_seen", got, 1);
    t_acc = cyc;
    clear_seen();
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    rdy_after = src ? b_ready : a_ready;
    got = done;
    if (!got) wait_done(got);
    chk("done_seen", got, 1);
    lat = cyc - t_acc;
  endtask

  // Both requesters valid in one cycle; first_b says who must win.
  task automatic run_pair(input logic op_a, input logic [1:0] idx_a,
                          input logic op_b, input logic [1:0] idx_b,
                          input logic first_b, input logic [3:0] exp_q);
    logic got;
    @(posedge clk); #1;
    a_valid = 1'b1; a_op = op_a; a_idx = idx_a;
    b_valid = 1'b1; b_op = op_b; b_idx = idx_b;
    @(negedge clk);
    chk("pair_a_ready", a_ready, !first_b);
    chk("pair_b_ready", b_ready, first_b);
    @(posedge clk); #1;
    if (first_b) b_valid = 1'b0; else a_valid = 1'b0;
    wait_done(got);
    chk("pair_done1", got, 1);
    chk("pair_src1", done_src, first_b);
    chk("pair_err1", err, 0);
    wait_ready(!first_b, got);
    chk("pair_ready2", got, 1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    wait_done(got);
    chk("pair_done2", got, 1);
    chk("pair_src2", done_src, !first_b);
    chk("pair_err2", err, 0);
    chk("pair_q", q_in, exp_q);
  endtask

  initial begin
    int   lat;
    logic rdy_after;
    logic got;
    int   ndone;
    logic [3:0] bit_m;

    vecs[0] = '{1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[1] = '{1'b1, 1'b0, 2'd2, 4'b0000};
    vecs[2] = '{1'b1, 1'b1, 2'd3, 4'b1000};
    vecs[3] = '{1'b0, 1'b0, 2'd3, 4'b0000};
    vecs[4] = '{1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[5] = '{1'b1, 1'b1, 2'd0, 4'b0011};
    vecs[6] = '{1'b0, 1'b0, 2'd1, 4'b0001};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 4'b0000};

    rst = 1'b1;
    a_valid = 1'b0; a_op = 1'b0; a_idx = 2'd0;
    b_valid = 1'b0; b_op = 1'b0; b_idx = 2'd0;
    c_valid = 1'b0; c_op = 1'b0; c_idx = 2'd0;
    c_b_valid = 1'b0; c_b_op = 1'b0; c_b_idx = 2'd0;
    clear_seen();
    prev_s = '0; prev_r = '0; prev_en = '0;

    // Continuous invariants on the latch drive lines.
    fork
      forever begin
        @(negedge clk);
        chk("inv_s_and_r", latch_s & latch_r, 0);
        chk("inv_en_onehot0", $onehot0(latch_en), 1);
        if (latch_en != '0 && prev_en != '0)
          chk("inv_sr_stable", {latch_s, latch_r}, {prev_s, prev_r});
        s_seen  = s_seen | latch_s;
        r_seen  = r_seen | latch_r;
        en_seen = en_seen | latch_en;
        if (latch_en != '0) en_cnt++;
        prev_s  = latch_s;
        prev_r  = latch_r;
        prev_en = latch_en;
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {busy, done, done_src, err, err_sticky}, 0);
    chk("rst_lines", {latch_s, latch_r, latch_en}, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_cmd(vecs[v].src, vecs[v].op, vecs[v].idx, lat, rdy_after);
      bit_m = 4'b0001 << vecs[v].idx;
      chk($sformatf("v%0d_latency", v), lat, 6);
      chk($sformatf("v%0d_ready_drop", v), rdy_after, 0);
      chk($sformatf("v%0d_done_src", v), done_src, vecs[v].src);
      chk($sformatf("v%0d_err", v), err, 0);
      chk($sformatf("v%0d_busy", v), busy, 1);
      chk($sformatf("v%0d_en_cycles", v), en_cnt, 2);
      chk($sformatf("v%0d_en_seen", v), en_seen, bit_m);
      chk($sformatf("v%0d_s_seen", v), s_seen, vecs[v].op ? bit_m : 4'b0000);
      chk($sformatf("v%0d_r_seen", v), r_seen, vecs[v].op ? 4'b0000 : bit_m);
      chk($sformatf("v%0d_q", v), q_in, vecs[v].exp_q);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), done, 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
    end

    // Last served was B: simultaneous pair goes A first.
    run_pair(1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 4'b0011);
    // One A command so that A is the last served, then B wins the tie.
    run_cmd(1'b0, 1'b1, 2'd2, lat, rdy_after);
    chk("a_set2_q", q_in, 4'b0111);
    run_pair(1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 4'b0100);

    // Q[3] stuck at 0: set 3 must report err and latch err_sticky.
    stuck0 = 4'b1000;
    run_cmd(1'b0, 1'b1, 2'd3, lat, rdy_after);
    chk("stuck_err", err, 1);
    chk("stuck_sticky", err_sticky, 1);
    chk("stuck_latency", lat, 6);
    run_cmd(1'b1, 1'b0, 2'd2, lat, rdy_after);
    chk("after_stuck_err", err, 0);
    chk("after_stuck_sticky", err_sticky, 1);
    chk("after_stuck_q", q_in, 4'b0000);
    run_cmd(1'b0, 1'b1, 2'd1, lat, rdy_after);
    chk("after_stuck2_err", err, 0);
    chk("after_stuck2_sticky", err_sticky, 1);
    stuck0 = 4'b0000;
    @(negedge clk);
    chk("unstuck_q", q_in, 4'b1010);

    // Reset in the first PULSE cycle of a set on latch 2.
    @(posedge clk); #1;
    a_valid = 1'b1; a_op = 1'b1; a_idx = 2'd2;
    wait_ready(1'b0, got);
    @(posedge clk); #1;
    a_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (latch_en != '0) got = 1'b1;
    end
    chk("rst_mid_pulse_seen", got, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {busy, done, done_src, err, err_sticky}, 0);
    chk("rst_mid_lines", {latch_s, latch_r, latch_en}, 0);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_mid_no_done", ndone, 0);
    chk("rst_mid_q", q_in, 4'b1110);
    run_cmd(1'b0, 1'b0, 2'd3, lat, rdy_after);
    chk("post_rst_latency", lat, 6);
    chk("post_rst_src", done_src, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_sticky", err_sticky, 0);
    chk("post_rst_q", q_in, 4'b0110);

    // Out-of-range index on the 3-latch instance.
    @(posedge clk); #1;
    c_valid = 1'b1; c_op = 1'b1; c_idx = 2'd3;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (c_ready) got = 1'b1;
    end
    chk("bad_ready", got, 1);
    @(posedge clk); #1;
    c_valid = 1'b0;
    @(negedge clk);
    chk("bad_done", c_done, 1);
    chk("bad_err", c_err, 1);
    chk("bad_src", c_done_src, 0);
    chk("bad_busy", c_busy, 1);
    chk("bad_lines", {c_s, c_r, c_en}, 0);
    chk("bad_b_ready", c_b_ready, 0);
    @(negedge clk);
    chk("bad_done_pulse", c_done, 0);
    chk("bad_idle", c_busy, 0);
    chk("bad_sticky", c_err_sticky, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Controller for a bank of N gated SR latches. Two requesters issue set/clear commands through valid/ready handshakes; a round-robin arbiter grants one at a time. The controller sequences each latch's S, R and gate (`clk` input of the latch) with setup/pulse/hold/settle phases and never drives S=R=1. It then checks the latch Q readback against the command and reports done/error.

## Interface
- `N`, 4: number of latches in the bank; 2..16.
- `PULSE_CYC`, 2: cycles the latch gate is held high; ≥1.
- `SETTLE_CYC`, 1: cycles between gate release and Q check; ≥1.
- Derived localparam `IDX_W = $clog2(N)` (min 1).

- `clk` in 1: the only clock; all logic is posedge.
- `rst` in 1: synchronous, active-high reset.
- `a_valid` in 1: requester A command valid.
- `a_op` in 1: A op; 1=set, 0=clear.
- `a_idx` in IDX_W: A target latch index.
- `a_ready` out 1: A command accepted this cycle.
- `b_valid`, `b_op`, `b_idx`, `b_ready`: same as A, for requester B.
- `latch_s` out N: S lines, one per latch.
- `latch_r` out N: R lines, one per latch.
- `latch_en` out N: gate lines (latch `clk` inputs), one per latch.
- `q_in` in N: Q readback from the latches.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when a command completes.
- `done_src` out 1: requester of the completed command; 0=A, 1=B. Valid with `done`.
- `err` out 1: mismatch or bad index on the completing command. Valid with `done`.
- `err_sticky` out 1: set by any `err`; cleared only by `rst`.

## Operation
- FSM states: IDLE → SETUP → PULSE → HOLD → SETTLE → CHECK → IDLE.
- IDLE
  - `x_ready` = (state==IDLE) & grant_x, combinational.
  - A handshake completes when valid&ready are both high in the same cycle.
  - op, idx and source are captured at that edge.
- Arbitration
  - Only one valid: that requester is granted.
  - Both valid: the requester not served last is granted. After reset, A has priority.
- SETUP: `latch_s[idx]`=op, `latch_r[idx]`=~op; `latch_en`=0.
- PULSE: S/R held; `latch_en[idx]`=1 for exactly PULSE_CYC cycles, counted by a down-counter.
- HOLD: 1 cycle; S/R held, `latch_en`=0.
- SETTLE: S=R=0 on all latches; wait SETTLE_CYC cycles.
- CHECK: 1 cycle.
  - `done`=1.
  - `err` = (q_in[idx] ≠ op).
  - `err_sticky` updated.
- Bad index (idx ≥ N, only possible when N is not a power of two)
  - Command is accepted.
  - FSM goes IDLE → CHECK directly, with no latch activity.
  - Completes with err=1.
- Invariants
  - For every bit i, `latch_s[i] & latch_r[i]` is never 1.
  - At most one bit of `latch_en` is high at a time.
  - S/R are stable for the whole time `latch_en` is high.
  - Outside the active index, S, R and en are 0.
- All outputs are registered except `a_ready` / `b_ready`.

## Timing
- Reset values: `latch_s`=`latch_r`=`latch_en`=0, `busy`=0, `done`=0, `done_src`=0, `err`=0, `err_sticky`=0, state IDLE, arbiter priority A.
- Command latency: with acceptance at edge T:
  - SETUP at T+1.
  - PULSE at T+2..T+1+PULSE_CYC.
  - HOLD at T+2+PULSE_CYC.
  - SETTLE for SETTLE_CYC cycles.
  - `done` at T+3+PULSE_CYC+SETTLE_CYC (defaults: T+6).
- The next accept is possible in the cycle after CHECK, giving a throughput of 1 command per 4+PULSE_CYC+SETTLE_CYC cycles.
- A requester holding valid while not granted keeps its command pending. Its op/idx must stay stable until ready.
- `rst` asserted mid-command:
  - All outputs return to reset values at the next edge.
  - The in-flight command is dropped with no `done`.
  - Latch contents are not altered by the controller.

## Structure
- Package `sr_ctrl_pkg`:
  - state enum `sr_state_t` (IDLE, SETUP, PULSE, HOLD, SETTLE, CHECK).
  - `OP_SET`=1'b1, `OP_CLR`=1'b0.
  - `SRC_A`=1'b0, `SRC_B`=1'b1.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `clk`, `rst`, req[1:0], `advance`.
  - Output: one-hot grant[1:0].
  - Priority pointer updates on `advance` (a completed handshake).
- Top: FSM, phase counter, command register, output decode.
- Bench instantiates N behavioural gated SR latches driven by `latch_s`/`latch_r`/`latch_en`, with Q fed back to `q_in`.

## Test plan
- Reset, then A set idx 2 → `a_ready` high for 1 cycle; `latch_en[2]` high for exactly 2 cycles; `done`=1 at T+6 with `done_src`=0, `err`=0; `q_in`=4'b0100.
- A and B both valid in the same cycle (A set 0, B set 1) → A served first, then B; `done_src` sequence 0,1; final Q=4'b0011. A second simultaneous pair is served B first.
- B clear idx 2 after it was set → `latch_r[2]`=1 during SETUP..HOLD; Q=4'b0000; `err`=0.
- Bench forces `q_in[3]` stuck at 0, then A set idx 3 → `done` with `err`=1; `err_sticky` stays 1 through later good commands until `rst`.
- `rst` pulsed during PULSE → next cycle all outputs 0, no `done`; a new A command then completes normally.
- Continuous assertion over all tests: no bit with S&R=1; `latch_en` is one-hot or zero; S/R are constant while any `en` is high.
